// File: rtl/sprite_motion_scheduler_if.sv
// Sprite scheduler bus: host config write port, renderer read port,
// vsync input and sweep status. The master side is the host/display,
// the slave side is the scheduler.
interface sprite_motion_scheduler_if #(
  parameter int unsigned NUM_SPR = 4,
  parameter int unsigned CORDW   = 11,
  parameter int unsigned SPEED_W = 4
);
  localparam int unsigned IDXW = $clog2(NUM_SPR) + 1;

  logic                      vsync;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [IDXW-1:0]           cfg_idx;
  logic signed [CORDW-1:0]   cfg_x;
  logic signed [CORDW-1:0]   cfg_y;
  logic signed [SPEED_W-1:0] cfg_vx;
  logic signed [SPEED_W-1:0] cfg_vy;
  logic [IDXW-1:0]           rd_idx;
  logic signed [CORDW-1:0]   rd_x;
  logic signed [CORDW-1:0]   rd_y;
  logic                      busy;
  logic                      frame_done;
  logic                      overrun;
  logic                      overrun_clr;

  modport master (
    output vsync, cfg_valid, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_vy,
           rd_idx, overrun_clr,
    input  cfg_ready, rd_x, rd_y, busy, frame_done, overrun
  );

  modport slave (
    input  vsync, cfg_valid, cfg_idx, cfg_x, cfg_y, cfg_vx, cfg_vy,
           rd_idx, overrun_clr,
    output cfg_ready, rd_x, rd_y, busy, frame_done, overrun
  );
endinterface

// File: rtl/sprite_motion_scheduler.sv
// Per-frame motion controller for NUM_SPR bouncing sprites.
// Each vsync rising edge starts a sweep that reads every slot (RD), applies
// its signed velocity and bounces it off the screen edges (WR). The host
// config port may write slots only while the scheduler is idle.
// Optional feature macro: SPRITE_SCHED_WRAP_EN -- sprites wrap around the
// screen edges instead of bouncing; velocity is then never changed.
module sprite_motion_scheduler #(
  parameter int unsigned NUM_SPR  = 4,
  parameter int unsigned CORDW    = 11,
  parameter int unsigned SPEED_W  = 4,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned SPR_W    = 100,
  parameter int unsigned SPR_H    = 100
) (
  input  logic                    clk_pix,
  input  logic                    btn_rst_n,
  sprite_motion_scheduler_if.slave bus
);

  localparam int unsigned IDXW = $clog2(NUM_SPR) + 1;
  localparam logic [IDXW-1:0]           LAST_IDX = IDXW'(NUM_SPR - 1);
  localparam logic signed [CORDW-1:0]   MAXX     = CORDW'(SCREEN_W - SPR_W);
  localparam logic signed [CORDW-1:0]   MAXY     = CORDW'(SCREEN_H - SPR_H);
  localparam logic signed [SPEED_W-1:0] V_ONE    = SPEED_W'(1);
  localparam logic signed [SPEED_W-1:0] V_MIN    = {1'b1, {(SPEED_W-1){1'b0}}};
  localparam logic signed [SPEED_W-1:0] V_SAT    = V_MIN + V_ONE;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic                      vsync_prev_q;
  logic                      overrun_q, overrun_d;
  logic                      vs_edge;
  logic                      cfg_wr;
  logic signed [SPEED_W-1:0] cfg_vx_sat, cfg_vy_sat;

  logic signed [CORDW-1:0]   x_q  [NUM_SPR];
  logic signed [CORDW-1:0]   y_q  [NUM_SPR];
  logic signed [SPEED_W-1:0] vx_q [NUM_SPR];
  logic signed [SPEED_W-1:0] vy_q [NUM_SPR];

  logic signed [CORDW-1:0]   sel_x, sel_y;
  logic signed [SPEED_W-1:0] sel_vx, sel_vy;
  logic signed [CORDW-1:0]   nx_q, ny_q;
  logic signed [SPEED_W-1:0] lvx_q, lvy_q;
  logic signed [CORDW-1:0]   wr_x, wr_y;
  logic signed [SPEED_W-1:0] wr_vx, wr_vy;

  function automatic logic signed [CORDW-1:0] sext(input logic signed [SPEED_W-1:0] v);
    return {{(CORDW-SPEED_W){v[SPEED_W-1]}}, v};
  endfunction

`ifdef SPRITE_SCHED_WRAP_EN
  localparam logic signed [CORDW-1:0] SPANX = CORDW'(SCREEN_W - SPR_W + 1);
  localparam logic signed [CORDW-1:0] SPANY = CORDW'(SCREEN_H - SPR_H + 1);

  function automatic logic signed [CORDW-1:0] wrap_pos(
    input logic signed [CORDW-1:0] n,
    input logic signed [CORDW-1:0] lim,
    input logic signed [CORDW-1:0] span
  );
    if (n[CORDW-1])  return n + span;
    else if (n > lim) return n - span;
    else              return n;
  endfunction
`else
  function automatic logic signed [CORDW-1:0] bounce_pos(
    input logic signed [CORDW-1:0] n,
    input logic signed [CORDW-1:0] lim
  );
    if (n[CORDW-1])  return '0;
    else if (n > lim) return lim;
    else              return n;
  endfunction

  function automatic logic bounce_hit(
    input logic signed [CORDW-1:0] n,
    input logic signed [CORDW-1:0] lim
  );
    return n[CORDW-1] || (n > lim);
  endfunction
`endif

  assign vs_edge    = bus.vsync & ~vsync_prev_q;
  assign cfg_wr     = bus.cfg_valid && (state_q == S_IDLE);
  assign cfg_vx_sat = (bus.cfg_vx == V_MIN) ? V_SAT : bus.cfg_vx;
  assign cfg_vy_sat = (bus.cfg_vy == V_MIN) ? V_SAT : bus.cfg_vy;

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.cfg_ready  = (state_q == S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.overrun    = overrun_q;

  // Control registers: FSM state, sweep index, vsync history, sticky overrun.
  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      vsync_prev_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vsync_prev_q <= bus.vsync;
      overrun_q    <= overrun_d;
    end
  end

  // Sweep sequencing and overrun flag; an edge seen while busy is dropped.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    if (bus.overrun_clr) overrun_d = 1'b0;
    if (vs_edge && (state_q != S_IDLE)) overrun_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (vs_edge) begin
          state_d = S_RD;
          idx_d   = '0;
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Slot selected by the sweep index.
  always_comb begin
    sel_x  = '0;
    sel_y  = '0;
    sel_vx = '0;
    sel_vy = '0;
    for (int unsigned i = 0; i < NUM_SPR; i++) begin
      if (idx_q == IDXW'(i)) begin
        sel_x  = x_q[i];
        sel_y  = y_q[i];
        sel_vx = vx_q[i];
        sel_vy = vy_q[i];
      end
    end
  end

  // RD stage: latch the candidate position and the current velocity.
  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      nx_q  <= '0;
      ny_q  <= '0;
      lvx_q <= '0;
      lvy_q <= '0;
    end else if (state_q == S_RD) begin
      nx_q  <= sel_x + sext(sel_vx);
      ny_q  <= sel_y + sext(sel_vy);
      lvx_q <= sel_vx;
      lvy_q <= sel_vy;
    end
  end

`ifdef SPRITE_SCHED_WRAP_EN
  // WR stage result: wrap position around the edges, keep velocity.
  always_comb begin
    wr_x  = wrap_pos(nx_q, MAXX, SPANX);
    wr_y  = wrap_pos(ny_q, MAXY, SPANY);
    wr_vx = lvx_q;
    wr_vy = lvy_q;
  end
`else
  // WR stage result: clamp to the edge and reverse velocity on a hit.
  always_comb begin
    wr_x  = bounce_pos(nx_q, MAXX);
    wr_y  = bounce_pos(ny_q, MAXY);
    wr_vx = bounce_hit(nx_q, MAXX) ? -lvx_q : lvx_q;
    wr_vy = bounce_hit(ny_q, MAXY) ? -lvy_q : lvy_q;
  end
`endif

  // Sprite table: sweep writes in WR, host writes only while idle.
  always_ff @(posedge clk_pix or negedge btn_rst_n) begin
    if (!btn_rst_n) begin
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        vx_q[i] <= V_ONE;
        vy_q[i] <= V_ONE;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SPR; i++) begin
        if ((state_q == S_WR) && (idx_q == IDXW'(i))) begin
          x_q[i]  <= wr_x;
          y_q[i]  <= wr_y;
          vx_q[i] <= wr_vx;
          vy_q[i] <= wr_vy;
        end else if (cfg_wr && (bus.cfg_idx == IDXW'(i))) begin
          x_q[i]  <= bus.cfg_x;
          y_q[i]  <= bus.cfg_y;
          vx_q[i] <= cfg_vx_sat;
          vy_q[i] <= cfg_vy_sat;
        end
      end
    end
  end

  // Renderer read port; out-of-range slots read as the origin.
  always_comb begin
    bus.rd_x = '0;
    bus.rd_y = '0;
    for (int unsigned i = 0; i < NUM_SPR; i++) begin
      if (bus.rd_idx == IDXW'(i)) begin
        bus.rd_x = x_q[i];
        bus.rd_y = y_q[i];
      end
    end
  end

endmodule

// File: tb/tb_sprite_motion_scheduler.sv
// Scoreboard bench for sprite_motion_scheduler (NUM_SPR=4, 640x480, 100x100).
// Stimulus pushes expected sprite tables and cycle-stamped status values;
// a monitor on the falling clock edge pops and compares them.
module tb_sprite_motion_scheduler;
  localparam int NUM_SPR = 4;
  localparam int CORDW   = 11;
  localparam int SPEED_W = 4;

  logic clk_pix;
  logic btn_rst_n;
  logic rb_req;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct packed {
    int cyc;
    int sel;
    int val;
  } st_t;

  st_t st_q[$];
  int  fr_edge_q[$];
  int  fr_exp_q[$];

  sprite_motion_scheduler_if #(.NUM_SPR(NUM_SPR), .CORDW(CORDW), .SPEED_W(SPEED_W)) bus ();

  sprite_motion_scheduler #(
    .NUM_SPR(NUM_SPR), .CORDW(CORDW), .SPEED_W(SPEED_W),
    .SCREEN_W(640), .SCREEN_H(480), .SPR_W(100), .SPR_H(100)
  ) dut (
    .clk_pix  (clk_pix),
    .btn_rst_n(btn_rst_n),
    .bus      (bus)
  );

  initial begin
    clk_pix = 1'b0;
    forever #10 clk_pix = ~clk_pix;
  end

  always @(posedge clk_pix) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: status expectations by cycle, table readback on frame_done or request.
  initial begin
    st_t s;
    int  e, ex, ey, v;
    string nm;
    bus.rd_idx = '0;
    forever begin
      @(negedge clk_pix);
      while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
        s = st_q.pop_front();
        case (s.sel)
          0:       begin v = int'(bus.busy);       nm = "busy";       end
          1:       begin v = int'(bus.cfg_ready);  nm = "cfg_ready";  end
          2:       begin v = int'(bus.frame_done); nm = "frame_done"; end
          default: begin v = int'(bus.overrun);    nm = "overrun";    end
        endcase
        chk(nm, v, s.val);
      end
      if (bus.frame_done || rb_req) begin
        chk("frame_expected", int'(fr_edge_q.size() != 0), 1);
        if (fr_edge_q.size() != 0) begin
          e = fr_edge_q.pop_front();
          if (e >= 0) chk("done_latency", cyc - e, 9);
          for (int sl = 0; sl <= NUM_SPR; sl++) begin
            if (sl == NUM_SPR) begin
              bus.rd_idx = 3'd5;
              ex = 0;
              ey = 0;
            end else begin
              bus.rd_idx = 3'(sl);
              ex = fr_exp_q.pop_front();
              ey = fr_exp_q.pop_front();
            end
            #1;
            chk($sformatf("rd_x[%0d]", sl), int'(bus.rd_x), ex);
            chk($sformatf("rd_y[%0d]", sl), int'(bus.rd_y), ey);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time budget exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pix);
    #2;
  endtask

  task automatic push_st(input int c, input int sel, input int val);
    st_t s;
    s.cyc = c;
    s.sel = sel;
    s.val = val;
    st_q.push_back(s);
  endtask

  task automatic push_frame(input int e, input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, input int x3, input int y3);
    fr_edge_q.push_back(e);
    fr_exp_q.push_back(x0); fr_exp_q.push_back(y0);
    fr_exp_q.push_back(x1); fr_exp_q.push_back(y1);
    fr_exp_q.push_back(x2); fr_exp_q.push_back(y2);
    fr_exp_q.push_back(x3); fr_exp_q.push_back(y3);
  endtask

  task automatic pulse_rb();
    rb_req = 1'b1;
    tick(1);
    rb_req = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bus.busy && k < 40) begin
      tick(1);
      k++;
    end
    chk("idle_reached", int'(bus.busy), 0);
    tick(1);
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int vx, input int vy);
    int k = 0;
    bus.cfg_idx   = 3'(idx);
    bus.cfg_x     = 11'(x);
    bus.cfg_y     = 11'(y);
    bus.cfg_vx    = 4'(vx);
    bus.cfg_vy    = 4'(vy);
    bus.cfg_valid = 1'b1;
    while (!bus.cfg_ready && k < 40) begin
      tick(1);
      k++;
    end
    chk("cfg_accept", int'(bus.cfg_ready), 1);
    tick(1);
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    int t;
    btn_rst_n       = 1'b0;
    rb_req          = 1'b0;
    bus.vsync       = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.cfg_idx     = '0;
    bus.cfg_x       = '0;
    bus.cfg_y       = '0;
    bus.cfg_vx      = '0;
    bus.cfg_vy      = '0;
    bus.overrun_clr = 1'b0;
    tick(2);
    btn_rst_n = 1'b1;
    tick(1);

    // Reset state
    push_st(cyc, 0, 0);
    push_st(cyc, 1, 1);
    push_st(cyc, 2, 0);
    push_st(cyc, 3, 0);
    push_frame(-1, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_rb();

    // Frame 1: every slot moves by +1,+1
    bus.vsync = 1'b1;
    t = cyc;
    push_frame(t, 1, 1, 1, 1, 1, 1, 1, 1);
    push_st(t + 1, 0, 1);
    push_st(t + 1, 1, 0);
    push_st(t + 8, 2, 0);
    push_st(t + 9, 0, 1);
    push_st(t + 10, 0, 0);
    push_st(t + 10, 1, 1);
    tick(2);
    bus.vsync = 1'b0;
    wait_idle();

    // Host configuration, including saturation and an out-of-range slot
    cfg_write(0, 538, 0, 3, 1);
    cfg_write(1, 50, 2, 0, -5);
    cfg_write(3, 100, 100, -8, 0);
    cfg_write(5, 7, 7, 1, 1);
    push_frame(-1, 538, 0, 50, 2, 1, 1, 100, 100);
    pulse_rb();

    // Frame 2: config write to slot 2 in the same cycle as the edge
    bus.cfg_idx   = 3'd2;
    bus.cfg_x     = 11'd10;
    bus.cfg_y     = 11'd20;
    bus.cfg_vx    = 4'sd2;
    bus.cfg_vy    = 4'sd1;
    bus.cfg_valid = 1'b1;
    bus.vsync     = 1'b1;
    t = cyc;
    push_st(t, 1, 1);
`ifdef SPRITE_SCHED_WRAP_EN
    push_frame(t, 0, 1, 50, 378, 12, 21, 93, 100);
`else
    push_frame(t, 540, 1, 50, 0, 12, 21, 93, 100);
`endif
    tick(1);
    bus.cfg_valid = 1'b0;
    tick(1);
    bus.vsync = 1'b0;
    wait_idle();

    // Frame 3: second edge while busy, host write held off until idle
    bus.vsync = 1'b1;
    t = cyc;
`ifdef SPRITE_SCHED_WRAP_EN
    push_frame(t, 3, 2, 50, 373, 14, 22, 86, 100);
`else
    push_frame(t, 537, 2, 50, 5, 14, 22, 86, 100);
`endif
    push_st(t + 2, 1, 0);
    push_st(t + 3, 3, 0);
    push_st(t + 5, 3, 1);
    push_st(t + 9, 3, 1);
    tick(2);
    bus.vsync     = 1'b0;
    bus.cfg_idx   = 3'd3;
    bus.cfg_x     = 11'd300;
    bus.cfg_y     = 11'd200;
    bus.cfg_vx    = 4'sd1;
    bus.cfg_vy    = -4'sd1;
    bus.cfg_valid = 1'b1;
    tick(2);
    bus.vsync = 1'b1;
    tick(2);
    bus.vsync = 1'b0;
    begin
      int k = 0;
      while (!bus.cfg_ready && k < 40) begin
        tick(1);
        k++;
      end
    end
    chk("cfg_ready_after_sweep", int'(bus.cfg_ready), 1);
    tick(1);
    bus.cfg_valid = 1'b0;
`ifdef SPRITE_SCHED_WRAP_EN
    push_frame(-1, 3, 2, 50, 373, 14, 22, 300, 200);
`else
    push_frame(-1, 537, 2, 50, 5, 14, 22, 300, 200);
`endif
    pulse_rb();
    push_st(cyc, 3, 1);
    bus.overrun_clr = 1'b1;
    tick(1);
    bus.overrun_clr = 1'b0;
    push_st(cyc, 3, 0);
    tick(1);

    // Frame 4: overrun set and clear in the same cycle, set wins
    bus.vsync = 1'b1;
    t = cyc;
`ifdef SPRITE_SCHED_WRAP_EN
    push_frame(t, 6, 3, 50, 368, 16, 23, 301, 199);
`else
    push_frame(t, 534, 3, 50, 10, 16, 23, 301, 199);
`endif
    push_st(t + 5, 3, 1);
    tick(2);
    bus.vsync = 1'b0;
    tick(2);
    bus.vsync       = 1'b1;
    bus.overrun_clr = 1'b1;
    tick(1);
    bus.overrun_clr = 1'b0;
    tick(1);
    bus.vsync = 1'b0;
    wait_idle();
    bus.overrun_clr = 1'b1;
    tick(1);
    bus.overrun_clr = 1'b0;
    push_st(cyc, 3, 0);
    tick(1);

    // Reset in the middle of a sweep
    bus.vsync = 1'b1;
    tick(2);
    bus.vsync = 1'b0;
    tick(3);
    btn_rst_n = 1'b0;
    push_st(cyc, 0, 0);
    push_st(cyc, 1, 1);
    push_frame(-1, 0, 0, 0, 0, 0, 0, 0, 0);
    pulse_rb();
    btn_rst_n = 1'b1;
    tick(2);

    // Frame 5: velocities back to +1 after reset
    bus.vsync = 1'b1;
    t = cyc;
    push_frame(t, 1, 1, 1, 1, 1, 1, 1, 1);
    tick(2);
    bus.vsync = 1'b0;
    wait_idle();
    tick(3);

    chk("frames_pending", fr_edge_q.size(), 0);
    chk("status_pending", st_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
